pc_redirect_unit: RTL and testbench

- Owns the fetch PC register and consumes the branch/jump redirect produced in EX (PcSel plus 32-bit target).
- Sequences sequential fetch, redirect with pipeline flush, halt drain and halted state.
- Sits between the EX-stage branch logic and instruction memory / IF-ID register.
- Generates PC, fetch-valid and flush controls for the front-end pipeline registers.

---
 rtl/fetch_pkg.sv | 6 +
 rtl/pc_redirect_unit.sv | 71 +++++++
 tb/tb_pc_redirect_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state type and constants for the fetch PC/redirect logic
package fetch_pkg;
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} fetch_state_t;
   localparam int PC_INC = 4;
   localparam logic [1:0] ALIGN_MASK = 2'b11;
endpackage

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with EX redirect, flush, halt drain and halted sequencing
module pc_redirect_unit
   import fetch_pkg::*;
#(
   parameter int PC_W = 9,
   parameter logic [PC_W-1:0] PC_RESET = '0,
   parameter int DRAIN_CYC = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             PcSel,
   input  logic [31:0]      BrPC,
   input  logic             halt_req,
   output logic [PC_W-1:0]  pc_out,
   output logic             fetch_valid,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             halted,
   output logic             misalign_err,
   output logic [CNT_W-1:0] redirect_cnt
);
   localparam int DW = DRAIN_CYC > 1 ? $clog2(DRAIN_CYC) : 1;
   fetch_state_t state, state_nx;
   logic [PC_W-1:0] pc_nx;
   logic [DW-1:0] drain_cnt, drain_nx;
   logic redirect, misaligned, take;
   logic unused_br;
   assign unused_br = ^BrPC;
   assign redirect = PcSel && state != HALTED;
   assign misaligned = |(BrPC[1:0] & ALIGN_MASK);
   assign take = redirect && !misaligned;
   assign flush_if_id = redirect;
   assign flush_id_ex = redirect;
   assign halted = state == HALTED;
   assign fetch_valid = state == RUN && !stall;
   // Redirect outranks everything; a misaligned target stops the core instead of fetching garbage.
   always_comb begin
      state_nx = state;
      pc_nx = pc_out;
      drain_nx = drain_cnt;
      if (redirect) begin
         state_nx = misaligned ? HALTED : RUN;
         pc_nx = misaligned ? pc_out : BrPC[PC_W-1:0];
      end else if (state == RUN) begin
         if (halt_req) begin
            state_nx = DRAIN;
            drain_nx = DW'(DRAIN_CYC - 1);
         end else if (!stall) pc_nx = pc_out + PC_W'(PC_INC);
      end else if (state == DRAIN) begin
         state_nx = drain_cnt == '0 ? HALTED : DRAIN;
         drain_nx = drain_cnt == '0 ? drain_cnt : drain_cnt - DW'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         pc_out <= PC_RESET;
         drain_cnt <= '0;
         misalign_err <= 1'b0;
         redirect_cnt <= '0;
      end else begin
         state <= state_nx;
         pc_out <= pc_nx;
         drain_cnt <= drain_nx;
         if (redirect && misaligned) misalign_err <= 1'b1;
         if (take && !(&redirect_cnt)) redirect_cnt <= redirect_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed plus random stimulus, scoreboard against a behavioural fetch model
module tb_pc_redirect_unit;
   localparam int PC_W = 9;
   localparam int DRAIN_CYC = 3;
   localparam int CNT_W = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int PC_MOD = 1 << PC_W;

   logic clk = 1'b0, reset = 1'b1, stall = 1'b0, PcSel = 1'b0, halt_req = 1'b0;
   logic [31:0] BrPC = '0;
   logic [PC_W-1:0] pc_out;
   logic fetch_valid, flush_if_id, flush_id_ex, halted, misalign_err;
   logic [CNT_W-1:0] redirect_cnt;

   pc_redirect_unit #(.PC_W(PC_W), .PC_RESET('0), .DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .stall(stall), .PcSel(PcSel), .BrPC(BrPC), .halt_req(halt_req),
      .pc_out(pc_out), .fetch_valid(fetch_valid), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
      .halted(halted), .misalign_err(misalign_err), .redirect_cnt(redirect_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int pc;
      bit fv, fi, fe, h, me;
      int cnt;
   } exp_t;
   exp_t q[$];

   int checks = 0, errors = 0;
   // Model: halt drain is "cycles left to wait", halted is a plain flag.
   int pc_m = 0, cnt_m = 0, drain_left = 0;
   bit halted_m = 0, err_m = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic cyc(input bit r, input bit st, input bit ps, input logic [31:0] br, input bit hr);
      exp_t e;
      bit running;
      @(posedge clk);
      #1;
      reset = r; stall = st; PcSel = ps; BrPC = br; halt_req = hr;
      if (r) begin
         pc_m = 0; cnt_m = 0; drain_left = 0; halted_m = 0; err_m = 0;
      end else begin
         running = !halted_m && drain_left == 0;
         e.pc = pc_m; e.fv = running && !st; e.fi = ps && !halted_m; e.fe = e.fi;
         e.h = halted_m; e.me = err_m; e.cnt = cnt_m;
         q.push_back(e);
         if (halted_m) begin
         end else if (ps) begin
            drain_left = 0;
            if (br % 4 != 0) begin
               err_m = 1; halted_m = 1;
            end else begin
               pc_m = int'(br % PC_MOD);
               if (cnt_m < CNT_MAX) cnt_m++;
            end
         end else if (running) begin
            if (hr) drain_left = DRAIN_CYC;
            else if (!st) pc_m = (pc_m + 4) % PC_MOD;
         end else begin
            drain_left--;
            if (drain_left == 0) halted_m = 1;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc_out", int'(pc_out), e.pc);
            chk("fetch_valid", int'(fetch_valid), int'(e.fv));
            chk("flush_if_id", int'(flush_if_id), int'(e.fi));
            chk("flush_id_ex", int'(flush_id_ex), int'(e.fe));
            chk("halted", int'(halted), int'(e.h));
            chk("misalign_err", int'(misalign_err), int'(e.me));
            chk("redirect_cnt", int'(redirect_cnt), e.cnt);
         end
      end
   end

   initial begin : stim
      logic [31:0] br;
      cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
      idle(4);
      cyc(0, 0, 1, 32'h0000_0040, 0); idle(1);
      cyc(0, 0, 1, 32'h0000_01FC, 0); idle(2);
      cyc(0, 0, 1, 32'hFFFF_F080, 0); idle(1);
      cyc(0, 0, 1, 32'h0000_0020, 0);
      cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 1, 32'h0000_0100, 0); idle(1);
      cyc(0, 0, 1, 32'h0000_0030, 0);
      cyc(0, 0, 0, 0, 1); idle(4);
      cyc(0, 0, 1, 32'h0000_0044, 0); cyc(0, 1, 0, 0, 1); idle(1);
      cyc(1, 0, 0, 0, 0); idle(2);
      cyc(0, 0, 0, 0, 1); idle(1);
      cyc(0, 1, 1, 32'h0000_0050, 0); idle(5);
      cyc(0, 0, 1, 32'h0000_0052, 0); idle(3);
      cyc(1, 0, 0, 0, 0); idle(1);
      cyc(0, 1, 1, 32'h0000_0010, 1); idle(2);
      for (int i = 0; i < 20; i++) begin
         br = $urandom & 32'hFFFF_FFFC;
         cyc(0, 0, 1, br, 0);
      end
      idle(2);
      for (int i = 0; i < 3000; i++) begin
         br = $urandom;
         if ($urandom_range(3) != 0) br[1:0] = 2'b00;
         cyc(($urandom_range(199) == 0) || (halted_m && $urandom_range(9) == 0),
             $urandom_range(3) == 0, $urandom_range(7) == 0, br, $urandom_range(31) == 0);
      end
      idle(1);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
